counter_4bit: RTL and testbench



---
 rtl/counter_pkg.sv | 4 +
 rtl/counter_4bit.sv | 33 +++
 tb/tb_counter_4bit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants for the counter block
package counter_pkg;
  localparam int COUNTER_DEFAULT_WIDTH = 4;
endpackage

// File: rtl/counter_4bit.sv
// rtl/counter_4bit.sv - free-running up-counter with enable, async reset and terminal count
module counter_4bit
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic             w_all_ones;

  // carry out of the top bit is dropped, giving natural modulo-2^WIDTH wrap
  assign w_next     = r_q + WIDTH'(1);
  assign w_all_ones = (r_q == {WIDTH{1'b1}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (enable) begin
      r_q <= w_next;
    end
  end

  assign q  = r_q;
  assign tc = w_all_ones & enable;

endmodule

// File: tb/tb_counter_4bit.sv
// tb/tb_counter_4bit.sv - scoreboard bench for counter_4bit
module tb_counter_4bit;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] q;
  logic       tc;

  logic [3:0] exp_q_q[$];
  logic       exp_tc_q[$];
  int         checks;
  int         errors;

  counter_4bit #(.WIDTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .q      (q),
    .tc     (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic model_tc(input logic en, input logic [3:0] eq);
    return en && (eq == 4'hF);
  endfunction

  task automatic pop_compare(input string name);
    logic [3:0] want_q;
    logic       want_tc;
    want_q  = exp_q_q.pop_front();
    want_tc = exp_tc_q.pop_front();
    checks++;
    if (q !== want_q) begin
      errors++;
      $display("FAIL %s q got %0d want %0d", name, q, want_q);
    end
    checks++;
    if (tc !== want_tc) begin
      errors++;
      $display("FAIL %s tc got %0b want %0b", name, tc, want_tc);
    end
  endtask

  // drive enable, predict the post-edge state, then compare 1 time unit after the edge
  task automatic cycle(input string name, input logic en, input logic [3:0] eq);
    enable = en;
    exp_q_q.push_back(eq);
    exp_tc_q.push_back(model_tc(en, eq) && !reset);
    @(posedge clk);
    #1;
    pop_compare(name);
  endtask

  task automatic check_now(input string name, input logic [3:0] eq);
    exp_q_q.push_back(eq);
    exp_tc_q.push_back(model_tc(enable, eq) && !reset);
    #1;
    pop_compare(name);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    check_now("reset_initial", 4'd0);
    cycle("reset_hold0", 1'b0, 4'd0);
    cycle("reset_hold1", 1'b0, 4'd0);
    reset = 1'b0;
    cycle("pre_async0", 1'b1, 4'd1);
    cycle("pre_async1", 1'b1, 4'd2);
    #2;
    reset = 1'b1;
    check_now("async_clear", 4'd0);
  endtask

  task automatic test_count();
    reset  = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= 5; i++) cycle($sformatf("count_%0d", i), 1'b1, 4'(i));
  endtask

  task automatic test_hold();
    cycle("hold0", 1'b0, 4'd5);
    cycle("hold1", 1'b0, 4'd5);
    for (int i = 6; i <= 8; i++) cycle($sformatf("resume_%0d", i), 1'b1, 4'(i));
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    #2;
    reset = 1'b1;
    check_now("mid_reset_clear", 4'd0);
    cycle("mid_reset_edge", 1'b1, 4'd0);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) cycle($sformatf("mid_restart_%0d", i), 1'b1, 4'(i));
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    check_now("wrap_start", 4'd0);
    reset = 1'b0;
    for (int i = 1; i <= 15; i++) cycle($sformatf("wrap_up_%0d", i), 1'b1, 4'(i));
    enable = 1'b0;
    check_now("tc_needs_enable", 4'd15);
    cycle("hold_at_15", 1'b0, 4'd15);
    enable = 1'b1;
    check_now("tc_at_15", 4'd15);
    cycle("wrap_to_0", 1'b1, 4'd0);
    cycle("after_wrap", 1'b1, 4'd1);
  endtask

  task automatic test_priority();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle($sformatf("priority_%0d", i), 1'b1, 4'd0);
    reset = 1'b0;
    cycle("priority_release", 1'b1, 4'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_count();
    test_hold();
    test_reset_mid();
    test_wrap();
    test_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
